tmds_decoder: RTL and testbench
===============================

// Module: tmds_decoder
// PURPOSE
//  Receive-side counterpart of the DVI output path: one TMDS channel decoder.
//  Takes 10-bit words from a 1:10 deserializer at pixel rate. Finds word alignment
//  from blanking control tokens and drives a bitslip request to the deserializer.
//  Once aligned, decodes each word to 8-bit video data, DE and C0/C1.
//  Three instances (blue/green/red) plus a channel deskew form the DVI input path.
// PARAMETERS
//  CTRL_RUN        32    consecutive identical control tokens required to declare lock
//  SEARCH_TIMEOUT  4096  pclk cycles without a qualifying token run before slip/unlock
//  SLIP_WAIT       16    pclk cycles to hold off after a bitslip pulse (deserializer settle)
//  ERR_W           16    width of err_cnt (optional feature only)
// PORTS
//  pclk       in   1   pixel clock; the only clock
//  reset_n    in   1   asynchronous, active-low reset
//  din        in   10  raw TMDS word, din[0] = first bit on the wire; valid every cycle
//  bitslip    out  1   one-cycle pulse: rotate deserializer word boundary by one bit
//  aligned    out  1   word alignment achieved; decoded outputs are meaningful
//  align_err  out  1   one-cycle pulse: 10 slips done with no lock (wrap of phase search)
//  dout       out  8   decoded pixel data (0 during blanking)
//  de         out  1   1 = data period word, 0 = control token
//  c0, c1     out  1   control bits from the last control token (hold during data)
//  err_cnt    out  ERR_W  isolated-token error count (only with TMDS_DEC_ERRCNT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in SEARCH, all counters 0. The reset is asynchronous.
//   Deassertion is taken synchronously. Reset mid-search discards the run and timeout counts.
//   Reset does not undo slips already applied to the deserializer.
//  Tokens: 10'b1101010100 (C1C0=00), 0010101011 (01), 0101010100 (10), 1010101011 (11).
//  Pipeline: stage 1 registers din and is_tok/tok_code. Stage 2 registers the decode.
//   Latency din -> dout/de/c0/c1 is exactly 2 pclk.
//  Decode: if token, de=0, dout=0, {c1,c0}=tok_code. Otherwise de=1, c0/c1 hold,
//   d = din[9] ? ~din[7:0] : din[7:0], dout[0]=d[0], and for i=1..7:
//   dout[i] = din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
//  run_cnt counts identical consecutive tokens. It saturates at CTRL_RUN.
//   A different token restarts it at 1; a non-token word clears it to 0.
//  FSM (alignment)
//   SEARCH: to_cnt increments each cycle.
//    run_cnt==CTRL_RUN -> LOCKED (aligned=1 on the next cycle).
//    to_cnt==SEARCH_TIMEOUT-1 -> SLIP: bitslip=1 for one cycle, slip_cnt++.
//   SLIP -> WAIT. WAIT holds SLIP_WAIT cycles, clears run_cnt/to_cnt, then returns to SEARCH.
//   slip_cnt wraps 9->0. On that wrap, align_err pulses in the same cycle as bitslip.
//   LOCKED: to_cnt is cleared whenever run_cnt==CTRL_RUN, otherwise it increments.
//    Timeout -> SEARCH, aligned=0, and no slip issued.
//  Lock detect and timeout in the same cycle: lock wins.
//  Outputs decode regardless of aligned. Consumers gate on aligned.
// CONFIGURATION
//  `TMDS_DEC_ERRCNT_EN defined:
//   While LOCKED, a token run of length 1..3 that is bounded by data words increments err_cnt.
//   err_cnt saturates at all-ones and clears on reset or on leaving LOCKED.
//  Not defined: the err_cnt port and its counting logic are absent.
// STRUCTURE
//  Package tmds_pkg holds: the four token constants, the align_state_t enum
//   (SEARCH, SLIP, WAIT, LOCKED), and a tok_decode function returning {is_tok, code[1:0]}.
//  Sub-module tmds_align_fsm holds the FSM, run_cnt, to_cnt and slip_cnt.
//   Its inputs are is_tok/code and its outputs are bitslip/aligned/align_err.
//  The data decode stays in the top module.
// TESTING
//  1 Reset low with din toggling -> all outputs 0. After release, aligned=0 and no bitslip
//    before SEARCH_TIMEOUT.
//  2 Aligned stream: 40x 10'b1101010100 then 10'h100 -> aligned=1, and zero bitslip pulses.
//    The token word gives de=0,c0=0,c1=0 two cycles later. 10'h100 gives de=1, dout=8'h00.
//    10'h2FF gives dout=8'hFE.
//  3 Same stream rotated by 3 bits, with a model that rotates on bitslip -> 7 bitslip pulses
//    spaced >= SEARCH_TIMEOUT+SLIP_WAIT, then aligned=1, and align_err never pulses.
//  4 Only data words (no tokens) -> bitslip every SEARCH_TIMEOUT+SLIP_WAIT+1 cycles.
//    align_err pulses on the 10th slip.
//  5 Locked, then tokens stop for SEARCH_TIMEOUT cycles -> aligned drops, with no bitslip.
//    Tokens restored -> re-lock after CTRL_RUN tokens.
//  6 (TMDS_DEC_ERRCNT_EN) Locked, inject 3 isolated single tokens in active video ->
//    err_cnt=3. Assert reset_n=0 in SEARCH mid-run -> run restarts, and err_cnt=0.

Source files
------------

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS decoder shared token constants, alignment states and token classifier
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        WAIT,
        LOCKED
    } align_state_t;

    // Returns {is_tok, code[1:0]} with code = {c1, c0}
    function automatic logic [2:0] tok_decode(input logic [9:0] word);
        logic [2:0] r;
        case (word)
            TOK_00:  r = 3'b100;
            TOK_01:  r = 3'b101;
            TOK_10:  r = 3'b110;
            TOK_11:  r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_decoder_if.sv
// rtl/tmds_decoder_if.sv - Decoded video bus of one TMDS channel
interface tmds_decoder_if;
    logic [7:0] dout;
    logic       de;
    logic       c0;
    logic       c1;

    modport master (output dout, de, c0, c1);
    modport slave  (input  dout, de, c0, c1);
endinterface

// File: rtl/tmds_align_fsm.sv
// rtl/tmds_align_fsm.sv - Word alignment search: token run detection, timeout, bitslip sequencing
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 32,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       is_tok,
    input  logic [1:0] code,
    output logic       bitslip,
    output logic       aligned,
    output logic       align_err
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);

    align_state_t     state_q, state_d;
    logic [RUN_W-1:0] run_cnt;
    logic [1:0]       last_code;
    logic [TO_W-1:0]  to_cnt;
    logic [WT_W-1:0]  wait_cnt;
    logic [3:0]       slip_cnt;
    logic             run_full, to_full, wait_done;

    assign run_full  = (run_cnt == RUN_W'(CTRL_RUN));
    assign to_full   = (to_cnt == TO_W'(SEARCH_TIMEOUT - 1));
    assign wait_done = (wait_cnt == WT_W'(SLIP_WAIT - 1));

    always_comb begin
        state_d   = state_q;
        bitslip   = 1'b0;
        aligned   = 1'b0;
        align_err = 1'b0;
        case (state_q)
            SEARCH: begin
                if (run_full)     state_d = LOCKED;
                else if (to_full) state_d = SLIP;
            end
            SLIP: begin
                bitslip   = 1'b1;
                align_err = (slip_cnt == 4'd9);
                state_d   = WAIT;
            end
            WAIT: begin
                if (wait_done) state_d = SEARCH;
            end
            LOCKED: begin
                aligned = 1'b1;
                // Loss of lock falls back to search without a slip: the phase was good once
                if (!run_full && to_full) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEARCH;
            run_cnt   <= '0;
            last_code <= '0;
            to_cnt    <= '0;
            wait_cnt  <= '0;
            slip_cnt  <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == WAIT || !is_tok)             run_cnt <= '0;
            else if (run_cnt != '0 && code == last_code) begin
                if (!run_full) run_cnt <= run_cnt + 1'b1;
            end else                                    run_cnt <= RUN_W'(1);
            if (is_tok) last_code <= code;

            if (state_d != state_q || state_q == SLIP || state_q == WAIT ||
                (state_q == LOCKED && run_full))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            wait_cnt <= (state_q == WAIT) ? wait_cnt + 1'b1 : '0;

            if (state_q == SLIP) slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - One TMDS channel decoder with token alignment; TMDS_DEC_ERRCNT_EN adds err_cnt
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 32,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16
`ifdef TMDS_DEC_ERRCNT_EN
    , parameter int ERR_W        = 16
`endif
) (
    input  logic            pclk,
    input  logic            reset_n,
    input  logic [9:0]      din,
    output logic            bitslip,
    output logic            aligned,
    output logic            align_err,
    tmds_decoder_if.master  vid
`ifdef TMDS_DEC_ERRCNT_EN
    , output logic [ERR_W-1:0] err_cnt
`endif
);

    logic [9:0] din_q;
    logic       is_tok_q;
    logic [1:0] code_q;
    logic [7:0] d, dec;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            din_q    <= '0;
            is_tok_q <= 1'b0;
            code_q   <= '0;
        end else begin
            din_q              <= din;
            {is_tok_q, code_q} <= tok_decode(din);
        end
    end

    always_comb begin
        d      = din_q[9] ? ~din_q[7:0] : din_q[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++)
            dec[i] = din_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vid.dout <= '0;
            vid.de   <= 1'b0;
            vid.c0   <= 1'b0;
            vid.c1   <= 1'b0;
        end else if (is_tok_q) begin
            vid.dout           <= '0;
            vid.de             <= 1'b0;
            {vid.c1, vid.c0}   <= code_q;
        end else begin
            vid.dout <= dec;
            vid.de   <= 1'b1;
        end
    end

    tmds_align_fsm #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) u_align (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .is_tok    (is_tok_q),
        .code      (code_q),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .align_err (align_err)
    );

`ifdef TMDS_DEC_ERRCNT_EN
    // iso_len saturates at 4 so any run longer than 3 never qualifies as isolated
    logic [2:0] iso_len;
    logic       seen_data;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            iso_len   <= '0;
            seen_data <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (is_tok_q) begin
                if (iso_len != 3'd4) iso_len <= iso_len + 3'd1;
            end else begin
                iso_len   <= '0;
                seen_data <= 1'b1;
            end
            if (!aligned)
                err_cnt <= '0;
            else if (!is_tok_q && seen_data && iso_len != 3'd0 && iso_len <= 3'd3 && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - Directed-vector bench for tmds_decoder (optional TMDS_DEC_ERRCNT_EN checks)
module tb_tmds_decoder;

    localparam int RUN    = 32;
    localparam int TMO    = 256;
    localparam int SWAIT  = 16;
    localparam int PERIOD = TMO + SWAIT + 1;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       pclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] din = 10'h000;
    logic       bitslip, aligned, align_err;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    tmds_decoder_if vid ();

    tmds_decoder #(
        .CTRL_RUN       (RUN),
        .SEARCH_TIMEOUT (TMO),
        .SLIP_WAIT      (SWAIT)
    ) dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .din       (din),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .align_err (align_err),
        .vid       (vid)
`ifdef TMDS_DEC_ERRCNT_EN
        , .err_cnt (err_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int slip_log[$];
    int aerr_log[$];

    always @(negedge pclk) begin
        cyc++;
        if (bitslip === 1'b1)   slip_log.push_back(cyc);
        if (align_err === 1'b1) aerr_log.push_back(cyc);
    end

    task automatic step(input logic [9:0] w);
        @(negedge pclk);
        #1;
        din = w;
    endtask

    task automatic apply_reset();
        @(negedge pclk);
        #1;
        reset_n = 1'b0;
        din     = 10'h000;
        repeat (3) step(10'h000);
    endtask

    task automatic release_reset(input logic [9:0] w);
        @(negedge pclk);
        #1;
        reset_n = 1'b1;
        din     = w;
    endtask

    function automatic logic [9:0] rot(input logic [9:0] w, input int r);
        logic [9:0] o;
        for (int i = 0; i < 10; i++) o[i] = w[(i + r) % 10];
        return o;
    endfunction

    task automatic test_reset();
        logic [13:0] outs;
        int n0;
        for (int i = 0; i < 6; i++) step(i[0] ? T11 : 10'h2FF);
        outs = {aligned, bitslip, align_err, vid.de, vid.c1, vid.c0, vid.dout};
        n_vec++; if (outs !== 14'h0) begin n_bad++; $display("FAIL reset_hold: got %h want 0000", outs); end

        release_reset(T11);
        repeat (40) step(T11);
        n_vec++; if ({aligned, vid.c1, vid.c0} !== 3'b111) begin n_bad++; $display("FAIL prelock_c11: got %b want 111", {aligned, vid.c1, vid.c0}); end

        @(negedge pclk);
        #2;
        reset_n = 1'b0;
        #1;
        outs = {aligned, bitslip, align_err, vid.de, vid.c1, vid.c0, vid.dout};
        n_vec++; if (outs !== 14'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0000", outs); end

        for (int i = 0; i < 6; i++) step(i[0] ? T00 : 10'h155);
        outs = {aligned, bitslip, align_err, vid.de, vid.c1, vid.c0, vid.dout};
        n_vec++; if (outs !== 14'h0) begin n_bad++; $display("FAIL reset_toggle: got %h want 0000", outs); end

        n0 = slip_log.size();
        release_reset(10'h100);
        repeat (TMO - 1) step(10'h100);
        n_vec++; if (slip_log.size() - n0 !== 0) begin n_bad++; $display("FAIL early_slip: got %0d want 0", slip_log.size() - n0); end
        n_vec++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL search_aligned: got %b want 0", aligned); end
        step(10'h100);
        n_vec++; if (bitslip !== 1'b1) begin n_bad++; $display("FAIL first_slip: got %b want 1", bitslip); end
    endtask

    task automatic test_decode();
        logic [9:0] words [12];
        logic [7:0] e_dout [10];
        logic       e_de [10];
        logic [1:0] e_c [10];
        int n0;
        words  = '{T00, 10'h100, 10'h2FF, 10'h0FF, T11, 10'h1AA, 10'h3C0, T01, 10'h155, T10, T00, T00};
        e_dout = '{8'h00, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'hFE, 8'h41, 8'h00, 8'hFF, 8'h00};
        e_de   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        e_c    = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10};

        apply_reset();
        n0 = slip_log.size();
        release_reset(T00);
        repeat (39) step(T00);
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL lock_40tok: got %b want 1", aligned); end

        for (int i = 0; i < 12; i++) begin
            step(words[i]);
            if (i >= 2) begin
                n_vec++; if (vid.dout !== e_dout[i-2]) begin n_bad++; $display("FAIL dec_dout[%0d]: got %h want %h", i-2, vid.dout, e_dout[i-2]); end
                n_vec++; if (vid.de !== e_de[i-2]) begin n_bad++; $display("FAIL dec_de[%0d]: got %b want %b", i-2, vid.de, e_de[i-2]); end
                n_vec++; if ({vid.c1, vid.c0} !== e_c[i-2]) begin n_bad++; $display("FAIL dec_c[%0d]: got %b want %b", i-2, {vid.c1, vid.c0}, e_c[i-2]); end
            end
        end
        n_vec++; if (slip_log.size() - n0 !== 0) begin n_bad++; $display("FAIL aligned_slips: got %0d want 0", slip_log.size() - n0); end
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL aligned_hold: got %b want 1", aligned); end
    endtask

    task automatic test_rotated();
        int base, a0, n;
        apply_reset();
        base = slip_log.size();
        a0   = aerr_log.size();
        release_reset(rot(T00, 3));
        repeat (8 * PERIOD) step(rot(T00, (3 + slip_log.size() - base) % 10));
        n = slip_log.size() - base;
        n_vec++; if (n !== 7) begin n_bad++; $display("FAIL rot_slips: got %0d want 7", n); end
        for (int k = 1; k < n && k < 7; k++) begin
            n_vec++;
            if (slip_log[base+k] - slip_log[base+k-1] < TMO + SWAIT) begin
                n_bad++; $display("FAIL rot_gap[%0d]: got %0d want >= %0d", k, slip_log[base+k] - slip_log[base+k-1], TMO + SWAIT);
            end
        end
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL rot_aligned: got %b want 1", aligned); end
        n_vec++; if (aerr_log.size() - a0 !== 0) begin n_bad++; $display("FAIL rot_align_err: got %0d want 0", aerr_log.size() - a0); end
    endtask

    task automatic test_no_tokens();
        int base, a0, n;
        apply_reset();
        base = slip_log.size();
        a0   = aerr_log.size();
        release_reset(10'h100);
        for (int i = 0; i < 10 * PERIOD + 5; i++) step(i[0] ? 10'h2FF : 10'h100);
        n = slip_log.size() - base;
        n_vec++; if (n !== 10) begin n_bad++; $display("FAIL nt_slips: got %0d want 10", n); end
        for (int k = 1; k < n && k < 10; k++) begin
            n_vec++;
            if (slip_log[base+k] - slip_log[base+k-1] !== PERIOD) begin
                n_bad++; $display("FAIL nt_gap[%0d]: got %0d want %0d", k, slip_log[base+k] - slip_log[base+k-1], PERIOD);
            end
        end
        n_vec++; if (aerr_log.size() - a0 !== 1) begin n_bad++; $display("FAIL nt_align_err_cnt: got %0d want 1", aerr_log.size() - a0); end
        if (n >= 10 && aerr_log.size() > a0) begin
            n_vec++; if (aerr_log[a0] !== slip_log[base+9]) begin n_bad++; $display("FAIL nt_align_err_pos: got %0d want %0d", aerr_log[a0], slip_log[base+9]); end
        end
        n_vec++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL nt_aligned: got %b want 0", aligned); end
    endtask

    task automatic test_unlock();
        int n0;
        apply_reset();
        release_reset(T00);
        repeat (43) step(T00);
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL ul_lock: got %b want 1", aligned); end
        n0 = slip_log.size();
        repeat (TMO + 2) step(10'h100);
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL ul_before_tmo: got %b want 1", aligned); end
        step(10'h100);
        n_vec++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ul_drop: got %b want 0", aligned); end
        repeat (3) step(10'h0FF);
        repeat (34) step(T10);
        n_vec++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL ul_relock_early: got %b want 0", aligned); end
        step(T10);
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL ul_relock: got %b want 1", aligned); end
        n_vec++; if (slip_log.size() - n0 !== 0) begin n_bad++; $display("FAIL ul_slips: got %0d want 0", slip_log.size() - n0); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        release_reset(T00);
        repeat (19) step(T00);
        @(negedge pclk);
        #1;
        reset_n = 1'b0;
        repeat (2) step(T00);
        release_reset(T00);
        repeat (33) step(T00);
        n_vec++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL mr_early: got %b want 0", aligned); end
        step(T00);
        n_vec++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL mr_lock: got %b want 1", aligned); end
    endtask

`ifdef TMDS_DEC_ERRCNT_EN
    task automatic test_errcnt();
        repeat (5) step(T00);
        n_vec++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL ec_start: got %0d want 0", err_cnt); end
        repeat (6) step(10'h100);
        for (int i = 0; i < 3; i++) begin
            step(T01);
            repeat (4) step(10'h100);
        end
        n_vec++; if (err_cnt !== 16'd3) begin n_bad++; $display("FAIL ec_three: got %0d want 3", err_cnt); end
        repeat (4) step(T01);
        repeat (4) step(10'h100);
        n_vec++; if (err_cnt !== 16'd3) begin n_bad++; $display("FAIL ec_run4: got %0d want 3", err_cnt); end
        apply_reset();
        n_vec++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL ec_reset: got %0d want 0", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_rotated();
        test_no_tokens();
        test_unlock();
        test_reset_midrun();
`ifdef TMDS_DEC_ERRCNT_EN
        test_errcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
